// File: rtl/pwm_duty_ctrl_pkg.sv
// Shared types and defaults for the PWM duty controller: FSM encoding,
// default constants and the saturating step helper.
package pwm_ctrl_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        PEND = 1'b1
    } pwm_state_e;

    localparam int PWM_PERIOD       = 50;
    localparam int PWM_STEP         = 5;
    localparam int PWM_DEBOUNCE_CYC = 16;
    localparam int PWM_REPEAT_CYC   = 64;

    // Math is done in int width, so neither direction can wrap before clamping.
    function automatic int sat_step(input int cur, input logic up, input logic dn,
                                    input int step, input int lim);
        int r;
        r = cur;
        if (up && !dn)
            r = (cur + step > lim) ? lim : cur + step;
        else if (dn && !up)
            r = (cur < step) ? 0 : cur - step;
        return r;
    endfunction

endpackage

// File: rtl/pwm_duty_ctrl_if.sv
// Button/period inputs and duty outputs of the PWM duty controller.
interface pwm_duty_ctrl_if #(
    parameter int DUTY_W = 8
);
    logic              inc_n;
    logic              dec_n;
    logic              period_wrap;
    logic [DUTY_W-1:0] duty;
    logic [DUTY_W-1:0] duty_target;
    logic              update_pending;
    logic              at_max;
    logic              at_min;

    modport master (
        output inc_n, dec_n, period_wrap,
        input  duty, duty_target, update_pending, at_max, at_min
    );

    modport slave (
        input  inc_n, dec_n, period_wrap,
        output duty, duty_target, update_pending, at_max, at_min
    );
endinterface

// File: rtl/pwm_duty_ctrl_btn_debounce.sv
// Active-low button front end: 2-FF sync, debounce, press pulse.
// PWM_AUTO_REPEAT_EN adds a repeat timer while the button is held.
module btn_debounce #(
    parameter int DEBOUNCE_CYC = 16
`ifdef PWM_AUTO_REPEAT_EN
   ,parameter int REPEAT_CYC   = 64
`endif
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic btn_ni,
    output logic press_o
);
    localparam int CNT_W = $clog2(DEBOUNCE_CYC);

    logic             sync1_q, sync2_q;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             flip;
    logic             press_first;

    assign flip        = (sync2_q != db_q) && (cnt_q == CNT_W'(DEBOUNCE_CYC - 1));
    // The pulse fires in the cycle the debounced level is committed low.
    assign press_first = flip && db_q;

    always_comb begin
        db_d  = db_q;
        cnt_d = cnt_q + CNT_W'(1);
        if (sync2_q == db_q) begin
            cnt_d = '0;
        end else if (flip) begin
            cnt_d = '0;
            db_d  = sync2_q;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync1_q <= 1'b1;
            sync2_q <= 1'b1;
            db_q    <= 1'b1;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_ni;
            sync2_q <= sync1_q;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef PWM_AUTO_REPEAT_EN
    localparam int RPT_W = $clog2(REPEAT_CYC);

    logic [RPT_W-1:0] rpt_q, rpt_d;
    logic             rpt_fire;

    assign rpt_fire = !db_q && (rpt_q == RPT_W'(REPEAT_CYC - 1));

    always_comb begin
        rpt_d = rpt_q + RPT_W'(1);
        if (db_q || rpt_fire)
            rpt_d = '0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) rpt_q <= '0;
        else         rpt_q <= rpt_d;
    end

    assign press_o = press_first || rpt_fire;
`else
    assign press_o = press_first;
`endif

endmodule

// File: rtl/pwm_duty_ctrl.sv
// Saturating PWM duty controller; new duty is committed only on period_wrap.
// Optional auto-repeat of held buttons via PWM_AUTO_REPEAT_EN.
module pwm_duty_ctrl
    import pwm_ctrl_pkg::*;
#(
    parameter int PERIOD       = PWM_PERIOD,
    parameter int STEP         = PWM_STEP,
    parameter int DUTY_W       = 8,
    parameter int DEBOUNCE_CYC = PWM_DEBOUNCE_CYC,
    parameter int REPEAT_CYC   = PWM_REPEAT_CYC
) (
    input  logic            clk,
    input  logic            reset,
    pwm_duty_ctrl_if.slave  bus
);
    if (PERIOD >= 2**DUTY_W || STEP < 1 || DEBOUNCE_CYC < 2 || REPEAT_CYC < 2) begin : g_bad_cfg
        $error("pwm_duty_ctrl: illegal parameter set");
    end

    logic              inc_ev, dec_ev;
    pwm_state_e        state_q, state_d;
    logic [DUTY_W-1:0] duty_q, duty_d;
    logic [DUTY_W-1:0] tgt_q, tgt_d;
    logic              at_max_q, at_min_q;

`ifdef PWM_AUTO_REPEAT_EN
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC)) u_inc (
        .clk_i(clk), .rst_ni(reset), .btn_ni(bus.inc_n), .press_o(inc_ev));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC), .REPEAT_CYC(REPEAT_CYC)) u_dec (
        .clk_i(clk), .rst_ni(reset), .btn_ni(bus.dec_n), .press_o(dec_ev));
`else
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_inc (
        .clk_i(clk), .rst_ni(reset), .btn_ni(bus.inc_n), .press_o(inc_ev));
    btn_debounce #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_dec (
        .clk_i(clk), .rst_ni(reset), .btn_ni(bus.dec_n), .press_o(dec_ev));
`endif

    always_comb begin
        tgt_d   = DUTY_W'(sat_step(int'(tgt_q), inc_ev, dec_ev, STEP, PERIOD));
        duty_d  = duty_q;
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (tgt_d != duty_q)
                    state_d = PEND;
            end
            PEND: begin
                // After a commit duty_q catches up, so the next cycle drops to IDLE.
                if (bus.period_wrap)
                    duty_d = tgt_d;
                if (tgt_d == duty_q)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q  <= IDLE;
            duty_q   <= '0;
            tgt_q    <= '0;
            at_max_q <= 1'b0;
            at_min_q <= 1'b1;
        end else begin
            state_q  <= state_d;
            duty_q   <= duty_d;
            tgt_q    <= tgt_d;
            at_max_q <= (tgt_d == DUTY_W'(PERIOD));
            at_min_q <= (tgt_d == '0);
        end
    end

    assign bus.duty           = duty_q;
    assign bus.duty_target    = tgt_q;
    assign bus.update_pending = (state_q == PEND);
    assign bus.at_max         = at_max_q;
    assign bus.at_min         = at_min_q;

endmodule

// File: tb/tb_pwm_duty_ctrl.sv
// Scoreboard bench for pwm_duty_ctrl: every expected output change is queued
// by the stimulus; a negedge monitor pops and compares on each observed change.
module tb_pwm_duty_ctrl;
    localparam int D = 16;
    localparam int R = 64;

    typedef struct packed {
        logic [7:0] duty;
        logic [7:0] tgt;
        logic       pend;
        logic       amax;
        logic       amin;
    } obs_t;

    logic clk;
    logic reset;
    int   checks = 0;
    int   errors = 0;
    obs_t exp_q[$];
    obs_t cur, last, e;
    bit   have_last = 0;

    pwm_duty_ctrl_if #(.DUTY_W(8)) ifc ();

    pwm_duty_ctrl #(
        .PERIOD(50), .STEP(5), .DUTY_W(8), .DEBOUNCE_CYC(D), .REPEAT_CYC(R)
    ) dut (
        .clk(clk), .reset(reset), .bus(ifc)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic obs_t mk(input int d, input int t, input bit p);
        obs_t o;
        o.duty = 8'(d);
        o.tgt  = 8'(t);
        o.pend = p;
        o.amax = (t == 50);
        o.amin = (t == 0);
        return o;
    endfunction

    task automatic chk(input string name, input int got, input int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end
    endtask

    // Monitor: any change of the output tuple must match the next queued entry.
    always @(negedge clk) begin
        cur.duty = ifc.duty;
        cur.tgt  = ifc.duty_target;
        cur.pend = ifc.update_pending;
        cur.amax = ifc.at_max;
        cur.amin = ifc.at_min;
        if (!have_last || cur !== last) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_change got=%h", cur);
            end else begin
                e = exp_q.pop_front();
                if (cur !== e) begin
                    errors++;
                    $display("FAIL sb_compare got=%h want=%h", cur, e);
                end
            end
            last      = cur;
            have_last = 1;
        end
    end

    task automatic press(input bit inc, input bit dec);
        @(negedge clk);
        ifc.inc_n = !inc;
        ifc.dec_n = !dec;
        repeat (D + 8) @(negedge clk);
        ifc.inc_n = 1'b1;
        ifc.dec_n = 1'b1;
        repeat (D + 8) @(negedge clk);
    endtask

    task automatic wrap();
        @(negedge clk);
        ifc.period_wrap = 1'b1;
        @(negedge clk);
        ifc.period_wrap = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int n, t, p;
        ifc.inc_n       = 1'b1;
        ifc.dec_n       = 1'b1;
        ifc.period_wrap = 1'b0;
        reset           = 1'b0;
        exp_q.push_back(mk(0, 0, 0));
        repeat (3) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // First press: latency, no commit without a wrap, then commit timing.
        exp_q.push_back(mk(0, 5, 1));
        @(negedge clk);
        ifc.inc_n = 1'b0;
        n = 0;
        while (ifc.duty_target != 8'd5 && n < 100) begin
            @(negedge clk);
            n++;
        end
        chk("inc_latency", n, D + 2);
        repeat (100 - n) @(negedge clk);
        chk("no_wrap_duty", int'(ifc.duty), 0);
        chk("no_wrap_pend", int'(ifc.update_pending), 1);
        ifc.inc_n = 1'b1;
        repeat (D + 8) @(negedge clk);
        exp_q.push_back(mk(5, 5, 1));
        exp_q.push_back(mk(5, 5, 0));
        @(negedge clk);
        ifc.period_wrap = 1'b1;
        @(negedge clk);
        ifc.period_wrap = 1'b0;
        chk("commit_duty", int'(ifc.duty), 5);
        chk("commit_pend_hold", int'(ifc.update_pending), 1);
        @(negedge clk);
        chk("commit_pend_clear", int'(ifc.update_pending), 0);

        // Presses 2..12 with a wrap each; saturation at 50.
        for (int i = 2; i <= 12; i++) begin
            t = (5 * i > 50) ? 50 : 5 * i;
            p = (5 * (i - 1) > 50) ? 50 : 5 * (i - 1);
            if (t != p) exp_q.push_back(mk(p, t, 1));
            press(1, 0);
            if (i >= 11) chk("sat_stay_idle", int'(ifc.update_pending), 0);
            if (t != p) begin
                exp_q.push_back(mk(t, t, 1));
                exp_q.push_back(mk(t, t, 0));
            end
            wrap();
        end
        chk("max_duty", int'(ifc.duty), 50);
        chk("at_max", int'(ifc.at_max), 1);

        // Back to zero, dec must not underflow.
        exp_q.push_back(mk(0, 0, 0));
        @(negedge clk);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        press(0, 1);
        chk("dec_floor_tgt", int'(ifc.duty_target), 0);
        chk("dec_floor_pend", int'(ifc.update_pending), 0);

        // Bouncing inc: toggles every 3 cycles, then held low -> one event.
        exp_q.push_back(mk(0, 5, 1));
        @(negedge clk);
        for (int k = 0; k < 13; k++) begin
            ifc.inc_n = (k % 2 == 1);
            repeat (3) @(negedge clk);
        end
        ifc.inc_n = 1'b0;
        repeat (D + 8) @(negedge clk);
        ifc.inc_n = 1'b1;
        repeat (D + 8) @(negedge clk);
        chk("bounce_one_event", int'(ifc.duty_target), 5);
        exp_q.push_back(mk(5, 5, 1));
        exp_q.push_back(mk(5, 5, 0));
        wrap();

        // Simultaneous inc and dec cancel.
        press(1, 1);
        chk("both_no_change", int'(ifc.duty_target), 5);
        chk("both_no_pend", int'(ifc.update_pending), 0);

        // Reach duty=10, target=15 pending, then reset asynchronously.
        exp_q.push_back(mk(5, 10, 1));
        press(1, 0);
        exp_q.push_back(mk(10, 10, 1));
        exp_q.push_back(mk(10, 10, 0));
        wrap();
        exp_q.push_back(mk(10, 15, 1));
        press(1, 0);
        chk("pend_tgt15", int'(ifc.duty_target), 15);
        exp_q.push_back(mk(0, 0, 0));
        @(negedge clk);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_duty", int'(ifc.duty), 0);
        chk("async_rst_tgt", int'(ifc.duty_target), 0);
        chk("async_rst_pend", int'(ifc.update_pending), 0);
        chk("async_rst_min", int'(ifc.at_min), 1);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        wrap();
        chk("no_commit_after_rst", int'(ifc.duty), 0);

`ifdef PWM_AUTO_REPEAT_EN
        exp_q.push_back(mk(0, 5, 1));
        exp_q.push_back(mk(0, 10, 1));
        exp_q.push_back(mk(0, 15, 1));
        exp_q.push_back(mk(0, 20, 1));
        @(negedge clk);
        ifc.inc_n = 1'b0;
        repeat (D + 2 + 3 * R + 10) @(negedge clk);
        ifc.inc_n = 1'b1;
        repeat (D + 10) @(negedge clk);
        chk("auto_repeat_tgt", int'(ifc.duty_target), 20);
`endif

        repeat (5) @(negedge clk);
        while (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            checks++;
            errors++;
            $display("FAIL sb_missing want=%h", e);
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
